// File: rtl/mem_exception_unit_pkg.sv
// Shared types and constants for the MEM-stage exception unit: pipeline exception
// flags, ExcCodes, CP0 register numbers, bit positions and the cause prioritiser.
package mem_exception_unit_pkg;

    typedef struct packed {
        logic Interrupt;
        logic WrongAddressinIF;
        logic TLBRefillinIF;
        logic TLBInvalidinIF;
        logic ReservedInstruction;
        logic Syscall;
        logic Break;
        logic Trap;
        logic Overflow;
        logic RdWrongAddressinMEM;
        logic WrWrongAddressinMEM;
        logic RdTLBRefillinMEM;
        logic RdTLBInvalidinMEM;
        logic WrTLBRefillinMEM;
        logic WrTLBInvalidinMEM;
        logic TLBModified;
        logic Eret;
        logic Refetch;
    } ExceptinPipeType;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_MOD  = 5'd1;
    localparam logic [4:0] EXC_TLBL = 5'd2;
    localparam logic [4:0] EXC_TLBS = 5'd3;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;
    localparam logic [4:0] EXC_TR   = 5'd13;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam int unsigned STATUS_IE    = 0;
    localparam int unsigned STATUS_EXL   = 1;
    localparam int unsigned STATUS_IM_LO = 8;
    localparam int unsigned STATUS_BEV   = 22;
    localparam int unsigned CAUSE_EXC_LO = 2;
    localparam int unsigned CAUSE_IP_LO  = 8;
    localparam int unsigned CAUSE_BD     = 31;

    // Result of prioritising one instruction's flags; sel covers Eret/Refetch too.
    typedef struct packed {
        logic       sel;
        logic       exc;
        logic [4:0] code;
        logic       refill;
        logic       badv_pc;
        logic       badv_data;
        logic       eret;
        logic       refetch;
    } exc_sel_t;

    function automatic exc_sel_t exc_prioritise(input ExceptinPipeType e);
        exc_sel_t s;
        s     = '0;
        s.sel = 1'b1;
        s.exc = 1'b1;
        if (e.Interrupt) begin
            s.code = EXC_INT;
        end else if (e.WrongAddressinIF) begin
            s.code    = EXC_ADEL;
            s.badv_pc = 1'b1;
        end else if (e.TLBRefillinIF) begin
            s.code    = EXC_TLBL;
            s.refill  = 1'b1;
            s.badv_pc = 1'b1;
        end else if (e.TLBInvalidinIF) begin
            s.code    = EXC_TLBL;
            s.badv_pc = 1'b1;
        end else if (e.ReservedInstruction) begin
            s.code = EXC_RI;
        end else if (e.Syscall) begin
            s.code = EXC_SYS;
        end else if (e.Break) begin
            s.code = EXC_BP;
        end else if (e.Trap) begin
            s.code = EXC_TR;
        end else if (e.Overflow) begin
            s.code = EXC_OV;
        end else if (e.RdWrongAddressinMEM) begin
            s.code      = EXC_ADEL;
            s.badv_data = 1'b1;
        end else if (e.WrWrongAddressinMEM) begin
            s.code      = EXC_ADES;
            s.badv_data = 1'b1;
        end else if (e.RdTLBRefillinMEM || e.RdTLBInvalidinMEM) begin
            s.code      = EXC_TLBL;
            s.refill    = e.RdTLBRefillinMEM;
            s.badv_data = 1'b1;
        end else if (e.WrTLBRefillinMEM || e.WrTLBInvalidinMEM) begin
            s.code      = EXC_TLBS;
            s.refill    = e.WrTLBRefillinMEM;
            s.badv_data = 1'b1;
        end else if (e.TLBModified) begin
            s.code      = EXC_MOD;
            s.badv_data = 1'b1;
        end else if (e.Eret) begin
            s.exc  = 1'b0;
            s.eret = 1'b1;
        end else if (e.Refetch) begin
            s.exc     = 1'b0;
            s.refetch = 1'b1;
        end else begin
            s.sel = 1'b0;
            s.exc = 1'b0;
        end
        return s;
    endfunction

endpackage

// File: rtl/mem_exception_unit_if.sv
// MEM-stage bundle between the pipeline and the exception unit: the instruction slot,
// the MTC0/MFC0 path and the flush/redirect results.
interface mem_exception_unit_if;
    import mem_exception_unit_pkg::*;

    logic            MEM_Valid;
    logic            MEM_Stall;
    ExceptinPipeType MEM_ExceptType;
    logic [31:0]     MEM_PC;
    logic            MEM_IsInDelaySlot;
    logic [31:0]     MEM_DataAddr;
    logic            CP0_We;
    logic [4:0]      CP0_Addr;
    logic [31:0]     CP0_WData;
    logic [31:0]     CP0_RData;
    logic            Flush;
    logic            Redirect_Valid;
    logic [31:0]     Redirect_PC;
    logic            Commit_Block;

    modport master (
        output MEM_Valid, MEM_Stall, MEM_ExceptType, MEM_PC, MEM_IsInDelaySlot, MEM_DataAddr,
        output CP0_We, CP0_Addr, CP0_WData,
        input  CP0_RData, Flush, Redirect_Valid, Redirect_PC, Commit_Block
    );

    modport slave (
        input  MEM_Valid, MEM_Stall, MEM_ExceptType, MEM_PC, MEM_IsInDelaySlot, MEM_DataAddr,
        input  CP0_We, CP0_Addr, CP0_WData,
        output CP0_RData, Flush, Redirect_Valid, Redirect_PC, Commit_Block
    );

endinterface

// File: rtl/cp0_int_sync.sv
// Multi-flop synchroniser bringing the asynchronous hardware interrupt lines into clk.
module cp0_int_sync #(
    parameter int unsigned Width  = 6,
    parameter int unsigned Stages = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [Width-1:0] async_in,
    output logic [Width-1:0] sync_out
);

    logic [Width-1:0] sync_q [Stages];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(Stages); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= async_in;
            for (int i = 1; i < int'(Stages); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync_out = sync_q[Stages-1];

endmodule

// File: rtl/mem_exception_unit.sv
// MEM-stage exception unit: prioritises pending causes, commits them precisely, owns the
// exception CP0 state and issues a registered flush/redirect to IF.
module mem_exception_unit
    import mem_exception_unit_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR    = 32'hBFC0_0380,
    parameter logic [31:0] REFILL_VECTOR = 32'hBFC0_0200,
    parameter int unsigned HW_INT_SYNC   = 2
) (
    input logic                 clk,
    input logic                 resetn,
    input logic [5:0]           ext_int,
    mem_exception_unit_if.slave bus
);

    logic [5:0]  ext_int_sync;

    logic        status_exl_q, status_exl_d;
    logic        status_ie_q, status_ie_d;
    logic [7:0]  status_im_q, status_im_d;
    logic        cause_bd_q, cause_bd_d;
    logic [1:0]  cause_ip_sw_q, cause_ip_sw_d;
    logic [4:0]  cause_exc_q, cause_exc_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        count_tick_q, count_tick_d;
    logic        timer_int_q, timer_int_d;
    logic        flush_q, flush_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    logic [7:0]      cause_ip;
    logic            int_pending;
    ExceptinPipeType exc_in;
    exc_sel_t        sel;
    logic            commit;
    logic            take;
    logic            mtc0;
    logic [31:0]     status_val;
    logic [31:0]     cause_val;

    cp0_int_sync #(
        .Width  (6),
        .Stages (HW_INT_SYNC)
    ) u_int_sync (
        .clk      (clk),
        .resetn   (resetn),
        .async_in (ext_int),
        .sync_out (ext_int_sync)
    );

    assign cause_ip    = {timer_int_q | ext_int_sync[5], ext_int_sync[4:0], cause_ip_sw_q};
    assign int_pending = status_ie_q & ~status_exl_q & |(cause_ip & status_im_q);

    always_comb begin
        exc_in           = bus.MEM_ExceptType;
        exc_in.Interrupt = bus.MEM_ExceptType.Interrupt | int_pending;
    end

    assign sel    = exc_prioritise(exc_in);
    assign commit = bus.MEM_Valid & ~bus.MEM_Stall & ~flush_q;
    assign take   = commit & sel.sel;
    // Only a clean committing instruction may write CP0.
    assign mtc0   = commit & ~sel.sel & bus.CP0_We;

    always_comb begin
        status_val                            = '0;
        status_val[STATUS_BEV]                = 1'b1;
        status_val[STATUS_IM_LO +: 8]         = status_im_q;
        status_val[STATUS_EXL]                = status_exl_q;
        status_val[STATUS_IE]                 = status_ie_q;
        cause_val                             = '0;
        cause_val[CAUSE_BD]                   = cause_bd_q;
        cause_val[CAUSE_IP_LO +: 8]           = cause_ip;
        cause_val[CAUSE_EXC_LO +: 5]          = cause_exc_q;
    end

    always_comb begin
        bus.CP0_RData = '0;
        case (bus.CP0_Addr)
            CP0_BADVADDR: bus.CP0_RData = badvaddr_q;
            CP0_COUNT:    bus.CP0_RData = count_q;
            CP0_COMPARE:  bus.CP0_RData = compare_q;
            CP0_STATUS:   bus.CP0_RData = status_val;
            CP0_CAUSE:    bus.CP0_RData = cause_val;
            CP0_EPC:      bus.CP0_RData = epc_q;
            default:      bus.CP0_RData = '0;
        endcase
    end

    always_comb begin
        count_tick_d     = ~count_tick_q;
        count_d          = count_q + {31'd0, count_tick_q};
        compare_d        = compare_q;
        timer_int_d      = timer_int_q | (count_q == compare_q);
        status_exl_d     = status_exl_q;
        status_ie_d      = status_ie_q;
        status_im_d      = status_im_q;
        cause_bd_d       = cause_bd_q;
        cause_ip_sw_d    = cause_ip_sw_q;
        cause_exc_d      = cause_exc_q;
        epc_d            = epc_q;
        badvaddr_d       = badvaddr_q;
        flush_d          = take;
        redirect_valid_d = take;
        redirect_pc_d    = redirect_pc_q;

        if (take) begin
            if (sel.exc) begin
                // Nested exceptions keep the EPC/BD of the outermost one.
                if (!status_exl_q) begin
                    epc_d      = bus.MEM_IsInDelaySlot ? bus.MEM_PC - 32'd4 : bus.MEM_PC;
                    cause_bd_d = bus.MEM_IsInDelaySlot;
                end
                status_exl_d = 1'b1;
                cause_exc_d  = sel.code;
                if (sel.badv_pc) begin
                    badvaddr_d = bus.MEM_PC;
                end else if (sel.badv_data) begin
                    badvaddr_d = bus.MEM_DataAddr;
                end
                redirect_pc_d = (sel.refill && !status_exl_q) ? REFILL_VECTOR : EXC_VECTOR;
            end else if (sel.eret) begin
                status_exl_d  = 1'b0;
                redirect_pc_d = epc_q;
            end else begin
                redirect_pc_d = bus.MEM_PC;
            end
        end

        if (mtc0) begin
            case (bus.CP0_Addr)
                CP0_COUNT: count_d = bus.CP0_WData;
                CP0_COMPARE: begin
                    compare_d   = bus.CP0_WData;
                    timer_int_d = 1'b0;
                end
                CP0_STATUS: begin
                    status_im_d  = bus.CP0_WData[STATUS_IM_LO +: 8];
                    status_exl_d = bus.CP0_WData[STATUS_EXL];
                    status_ie_d  = bus.CP0_WData[STATUS_IE];
                end
                CP0_CAUSE: cause_ip_sw_d = bus.CP0_WData[CAUSE_IP_LO +: 2];
                CP0_EPC:   epc_d = bus.CP0_WData;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            status_exl_q     <= 1'b0;
            status_ie_q      <= 1'b0;
            status_im_q      <= '0;
            cause_bd_q       <= 1'b0;
            cause_ip_sw_q    <= '0;
            cause_exc_q      <= '0;
            epc_q            <= '0;
            badvaddr_q       <= '0;
            count_q          <= '0;
            compare_q        <= '0;
            count_tick_q     <= 1'b0;
            timer_int_q      <= 1'b0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            status_exl_q     <= status_exl_d;
            status_ie_q      <= status_ie_d;
            status_im_q      <= status_im_d;
            cause_bd_q       <= cause_bd_d;
            cause_ip_sw_q    <= cause_ip_sw_d;
            cause_exc_q      <= cause_exc_d;
            epc_q            <= epc_d;
            badvaddr_q       <= badvaddr_d;
            count_q          <= count_d;
            compare_q        <= compare_d;
            count_tick_q     <= count_tick_d;
            timer_int_q      <= timer_int_d;
            flush_q          <= flush_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign bus.Flush          = flush_q;
    assign bus.Redirect_Valid = redirect_valid_q;
    assign bus.Redirect_PC    = redirect_pc_q;
    assign bus.Commit_Block   = take;

endmodule

// File: tb/tb_mem_exception_unit.sv
// Directed bench for mem_exception_unit: priority, EPC/BD/BadVAddr capture, vectors,
// Eret/Refetch, stall hold, MTC0 masking, interrupt sync and the Count/Compare timer.
module tb_mem_exception_unit;
    import mem_exception_unit_pkg::*;

    localparam logic [31:0] EXC_VEC    = 32'hBFC0_0380;
    localparam logic [31:0] REFILL_VEC = 32'hBFC0_0200;

    logic        clk = 1'b0;
    logic        resetn;
    logic [5:0]  ext_int;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    ExceptinPipeType e;
    logic [31:0]     d, c0, c1;
    logic            fired;

    mem_exception_unit_if bus ();

    mem_exception_unit dut (
        .clk     (clk),
        .resetn  (resetn),
        .ext_int (ext_int),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.MEM_Valid         = 1'b0;
        bus.MEM_Stall         = 1'b0;
        bus.MEM_ExceptType    = '0;
        bus.MEM_PC            = '0;
        bus.MEM_IsInDelaySlot = 1'b0;
        bus.MEM_DataAddr      = '0;
        bus.CP0_We            = 1'b0;
        bus.CP0_Addr          = '0;
        bus.CP0_WData         = '0;
    endtask

    task automatic rd(input logic [4:0] addr, output logic [31:0] data);
        bus.CP0_Addr = addr;
        #1;
        data = bus.CP0_RData;
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        bus.MEM_Valid = 1'b1;
        bus.CP0_We    = 1'b1;
        bus.CP0_Addr  = addr;
        bus.CP0_WData = data;
        step();
        idle_inputs();
    endtask

    // Drive one committing instruction, then check the one-cycle flush/redirect pulse.
    task automatic issue(input ExceptinPipeType exc, input logic [31:0] pc, input logic ds,
                         input logic [31:0] daddr, input logic [31:0] exp_pc, input string tag);
        bus.MEM_Valid         = 1'b1;
        bus.MEM_ExceptType    = exc;
        bus.MEM_PC            = pc;
        bus.MEM_IsInDelaySlot = ds;
        bus.MEM_DataAddr      = daddr;
        #1;
        check({tag, "_block"}, 32'(bus.Commit_Block), 32'd1);
        step();
        idle_inputs();
        check({tag, "_flush"}, 32'(bus.Flush), 32'd1);
        check({tag, "_rvalid"}, 32'(bus.Redirect_Valid), 32'd1);
        check({tag, "_rpc"}, bus.Redirect_PC, exp_pc);
        step();
        check({tag, "_flush_end"}, 32'(bus.Flush), 32'd0);
    endtask

    initial begin
        idle_inputs();
        ext_int = '0;
        resetn  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_flush", 32'(bus.Flush), 32'd0);
        check("rst_rvalid", 32'(bus.Redirect_Valid), 32'd0);
        check("rst_rpc", bus.Redirect_PC, 32'd0);
        rd(CP0_STATUS, d);   check("rst_status", d, 32'h0040_0000);
        rd(CP0_CAUSE, d);    check("rst_cause", d, 32'd0);
        rd(CP0_EPC, d);      check("rst_epc", d, 32'd0);
        rd(CP0_COUNT, d);    check("rst_count", d, 32'd0);
        rd(CP0_BADVADDR, d); check("rst_badv", d, 32'd0);
        resetn = 1'b1;
        step();

        rd(CP0_COUNT, c0);
        step();
        step();
        rd(CP0_COUNT, c1);
        check("count_half_rate", c1 - c0, 32'd1);

        e = '0; e.Overflow = 1'b1;
        issue(e, 32'h8000_0100, 1'b0, 32'd0, EXC_VEC, "ov");
        rd(CP0_CAUSE, d);  check("ov_code", 32'(d[6:2]), 32'd12);
        rd(CP0_EPC, d);    check("ov_epc", d, 32'h8000_0100);
        rd(CP0_STATUS, d); check("ov_exl", 32'(d[1]), 32'd1);

        e = '0; e.Eret = 1'b1;
        issue(e, 32'h0000_1234, 1'b0, 32'd0, 32'h8000_0100, "eret1");
        rd(CP0_STATUS, d); check("eret1_exl", 32'(d[1]), 32'd0);

        e = '0; e.Syscall = 1'b1; e.Overflow = 1'b1;
        issue(e, 32'h8000_0204, 1'b1, 32'd0, EXC_VEC, "sys_ds");
        rd(CP0_CAUSE, d); check("sys_code", 32'(d[6:2]), 32'd8);
        check("sys_bd", 32'(d[31]), 32'd1);
        rd(CP0_EPC, d);   check("sys_epc", d, 32'h8000_0200);

        e = '0; e.Eret = 1'b1;
        issue(e, 32'd0, 1'b0, 32'd0, 32'h8000_0200, "eret2");

        e = '0; e.RdWrongAddressinMEM = 1'b1;
        issue(e, 32'h8000_0300, 1'b0, 32'h0000_1003, EXC_VEC, "adel");
        rd(CP0_CAUSE, d);    check("adel_code", 32'(d[6:2]), 32'd4);
        check("adel_bd", 32'(d[31]), 32'd0);
        rd(CP0_BADVADDR, d); check("adel_badv", d, 32'h0000_1003);

        mtc0(CP0_EPC, 32'h8000_0400);
        rd(CP0_EPC, d); check("mtc0_epc", d, 32'h8000_0400);

        // Eret held under stall: no commit, no flush until the stall drops.
        bus.MEM_Valid      = 1'b1;
        bus.MEM_Stall      = 1'b1;
        bus.MEM_ExceptType = '0;
        bus.MEM_ExceptType.Eret = 1'b1;
        #1;
        check("stall_block", 32'(bus.Commit_Block), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_flush", 32'(bus.Flush), 32'd0);
        end
        bus.MEM_Stall = 1'b0;
        #1;
        check("unstall_block", 32'(bus.Commit_Block), 32'd1);
        step();
        idle_inputs();
        check("unstall_flush", 32'(bus.Flush), 32'd1);
        check("unstall_rpc", bus.Redirect_PC, 32'h8000_0400);
        step();
        check("unstall_flush_end", 32'(bus.Flush), 32'd0);
        rd(CP0_STATUS, d); check("unstall_exl", 32'(d[1]), 32'd0);

        mtc0(CP0_STATUS, 32'hFFFF_FFFF);
        rd(CP0_STATUS, d); check("status_mask", d, 32'h0040_FF03);
        mtc0(CP0_STATUS, 32'd0);
        rd(CP0_STATUS, d); check("status_clear", d, 32'h0040_0000);

        // An excepting instruction carrying an MTC0 must not write CP0.
        bus.CP0_We    = 1'b1;
        bus.CP0_Addr  = CP0_STATUS;
        bus.CP0_WData = 32'h0000_FF01;
        e = '0; e.Syscall = 1'b1;
        issue(e, 32'h8000_0500, 1'b0, 32'd0, EXC_VEC, "sys_mtc0");
        rd(CP0_STATUS, d); check("sys_mtc0_status", d, 32'h0040_0002);
        e = '0; e.Eret = 1'b1;
        issue(e, 32'd0, 1'b0, 32'd0, 32'h8000_0500, "eret3");

        mtc0(CP0_CAUSE, 32'hFFFF_FFFF);
        rd(CP0_CAUSE, d); check("cause_mask", d & 32'h8000_037C, 32'h0000_0320);
        mtc0(CP0_CAUSE, 32'd0);

        ext_int = 6'b000100;
        repeat (3) step();
        rd(CP0_CAUSE, d); check("ext_int_ip4_set", 32'(d[12]), 32'd1);
        ext_int = '0;
        repeat (3) step();
        rd(CP0_CAUSE, d); check("ext_int_ip4_clr", 32'(d[12]), 32'd0);

        e = '0; e.Trap = 1'b1;
        issue(e, 32'h8000_0600, 1'b0, 32'd0, EXC_VEC, "trap");
        rd(CP0_CAUSE, d); check("trap_code", 32'(d[6:2]), 32'd13);
        e = '0; e.TLBRefillinIF = 1'b1;
        issue(e, 32'h8000_0700, 1'b0, 32'd0, EXC_VEC, "refill_exl1");
        rd(CP0_EPC, d);      check("refill_exl1_epc", d, 32'h8000_0600);
        rd(CP0_BADVADDR, d); check("refill_exl1_badv", d, 32'h8000_0700);
        rd(CP0_CAUSE, d);    check("refill_exl1_code", 32'(d[6:2]), 32'd2);
        e = '0; e.Eret = 1'b1;
        issue(e, 32'd0, 1'b0, 32'd0, 32'h8000_0600, "eret4");

        e = '0; e.RdTLBRefillinMEM = 1'b1;
        issue(e, 32'h8000_0800, 1'b0, 32'h0000_2000, REFILL_VEC, "refill_exl0");
        rd(CP0_BADVADDR, d); check("refill_exl0_badv", d, 32'h0000_2000);
        rd(CP0_CAUSE, d);    check("refill_exl0_code", 32'(d[6:2]), 32'd2);
        e = '0; e.Eret = 1'b1;
        issue(e, 32'd0, 1'b0, 32'd0, 32'h8000_0800, "eret5");

        e = '0; e.Refetch = 1'b1;
        issue(e, 32'h8000_0900, 1'b0, 32'd0, 32'h8000_0900, "refetch");
        rd(CP0_EPC, d);    check("refetch_epc", d, 32'h8000_0800);
        rd(CP0_STATUS, d); check("refetch_exl", 32'(d[1]), 32'd0);

        mtc0(CP0_COUNT, 32'h0000_0100);
        rd(CP0_COUNT, d); check("count_write_wins", d, 32'h0000_0100);

        mtc0(CP0_COUNT, 32'd0);
        mtc0(CP0_COMPARE, 32'd10);
        mtc0(CP0_STATUS, 32'h0000_8001);
        rd(CP0_CAUSE, d); check("timer_cleared", 32'(d[15]), 32'd0);
        fired = 1'b0;
        for (int i = 0; i < 40 && !fired; i++) begin
            step();
            rd(CP0_CAUSE, d);
            fired = d[15];
        end
        check("timer_fire", 32'(fired), 32'd1);
        rd(CP0_COUNT, d);
        check("timer_count", 32'(d == 32'd10 || d == 32'd11), 32'd1);

        e = '0;
        issue(e, 32'h8000_0A00, 1'b0, 32'd0, EXC_VEC, "int");
        rd(CP0_CAUSE, d);  check("int_code", 32'(d[6:2]), 32'd0);
        rd(CP0_EPC, d);    check("int_epc", d, 32'h8000_0A00);
        rd(CP0_STATUS, d); check("int_exl", 32'(d[1]), 32'd1);
        mtc0(CP0_COMPARE, 32'h0000_1000);
        step();
        rd(CP0_CAUSE, d); check("timer_ack", 32'(d[15]), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_exception_unit.md
Name: mem_exception_unit

Overview:
- MEM-stage consumer of the per-instruction exception vector that EXE and earlier stages build up, including the Overflow flag raised by the ALU.
- Prioritises pending causes and commits exceptions precisely. Owns the exception-related CP0 state: Status.EXL/IE/IM, Cause, EPC, BadVAddr, Count and Compare.
- Drives a registered pipeline flush and PC redirect to IF.
- Sits between the EXE/MEM pipeline register and the MEM/WB register, beside the CP0 read/write path used by MFC0/MTC0.

Parameters:
- EXC_VECTOR, 32'hBFC0_0380, general exception entry (BEV=1).
- REFILL_VECTOR, 32'hBFC0_0200, TLB refill entry when EXL=0.
- HW_INT_SYNC, 2, synchroniser depth for ext_int.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- ext_int  in  6  hardware interrupt lines, asynchronous
- MEM_Valid  in  1  MEM slot holds a live instruction
- MEM_Stall  in  1  MEM cannot advance (D-cache busy)
- MEM_ExceptType  in  ExceptinPipeType  accumulated exception flags
- MEM_PC  in  32  PC of MEM instruction
- MEM_IsInDelaySlot  in  1  instruction sits in a branch delay slot
- MEM_DataAddr  in  32  load/store effective address
- CP0_We  in  1  MTC0 write strobe, qualified by MEM_Valid
- CP0_Addr  in  5  CP0 register number (9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC; 8 BadVAddr is read-only)
- CP0_WData  in  32  MTC0 data
- CP0_RData  out  32  combinational read of CP0_Addr
- Flush  out  1  registered; squash IF..MEM
- Redirect_Valid  out  1  registered; load Redirect_PC into PC
- Redirect_PC  out  32  registered target
- Commit_Block  out  1  MEM instruction must not write RF/memory this cycle

Behaviour:
- Reset values:
  - Status: EXL=0, IE=0, IM=0, BEV=1 (read-only).
  - Cause = 0; EPC = 0; BadVAddr = 0; Count = 0; Compare = 0.
  - Count half-rate toggle = 0; synchronisers = 0.
  - Flush = 0; Redirect_Valid = 0; Redirect_PC = 0.
- Interrupts:
  - Cause.IP[7:2] = {timer_int, sync(ext_int[4:0])}. ext_int[5] is ORed with timer_int into IP7.
  - IP[1:0] are written only by MTC0.
  - int_pending = IE & !EXL & |(IP & IM). It is ORed into the Interrupt flag of the MEM instruction.
- Timer:
  - Count increments every second clk.
  - timer_int sets when Count==Compare and stays set until an MTC0 to Compare.
- Commit condition: MEM_Valid & !MEM_Stall & !Flush. No commit in the cycle Flush is high.
- Priority, highest first, with ExcCode:
  1. Interrupt 0
  2. WrongAddressinIF 4
  3. TLBRefillinIF 2
  4. TLBInvalidinIF 2
  5. ReservedInstruction 10
  6. Syscall 8
  7. Break 9
  8. Trap 13
  9. Overflow 12
  10. RdWrongAddressinMEM 4
  11. WrWrongAddressinMEM 5
  12. RdTLBRefillinMEM / RdTLBInvalidinMEM 2
  13. WrTLBRefillinMEM / WrTLBInvalidinMEM 3
  14. TLBModified 1
  15. Eret
  16. Refetch
- Exception commit takes effect on the next clk edge:
  - If EXL=0: EPC = InDelaySlot ? PC-4 : PC; Cause.BD = InDelaySlot.
  - If EXL=1: EPC and BD are unchanged.
  - EXL is set to 1 and Cause.ExcCode is written.
  - BadVAddr is written: MEM_PC for IF address/TLB faults, MEM_DataAddr for MEM address/TLB faults, unchanged otherwise.
  - Flush=1, Redirect_Valid=1 for exactly one cycle.
  - Redirect_PC = REFILL_VECTOR for refill causes when EXL was 0, else EXC_VECTOR.
- Eret commit: EXL cleared; Flush/Redirect pulse to EPC. When EXL is already 0, the pulse still issues.
- Refetch commit: Flush/Redirect pulse to MEM_PC; no CP0 update.
- Commit_Block: combinationally high whenever any cause, including Eret and Refetch, is selected at commit.
- MTC0:
  - Applied on commit only, and only when no cause is selected. An excepting instruction never writes CP0.
  - Writes are masked: Status writes IE/IM/EXL; Cause writes IP[1:0] only.
  - MTC0 to Count in the same cycle as an increment: the written value wins.
- Stall: while MEM_Stall is high, nothing commits and flags wait; the timer keeps running.
- Reset mid-pulse: Flush/Redirect deassert immediately (asynchronous).

Decomposition:
- Shared package: ExceptinPipeType (already shared), ExcCode localparams, CP0 register-number constants, Status/Cause bit-position constants.
- Sub-module cp0_int_sync: parameterised multi-flop synchroniser for ext_int.

Test Plan:
- Overflow only, PC=0x8000_0100, not in delay slot, EXL=0 -> next cycle Flush=1, Redirect_PC=0xBFC0_0380; ExcCode=12; EPC=0x8000_0100; EXL=1.
- Syscall+Overflow both set, delay slot, PC=0x8000_0204 -> ExcCode=8; EPC=0x8000_0200; BD=1.
- RdWrongAddressinMEM, DataAddr=0x0000_1003 -> ExcCode=4; BadVAddr=0x0000_1003; Commit_Block high in the commit cycle.
- Compare=10 via MTC0, IE=1, IM[7]=1 -> Count reaches 10 after 20 cycles; next valid instruction takes ExcCode=0. MTC0 Compare then clears IP7.
- Exception held under MEM_Stall for 5 cycles -> no Flush until stall drops, then exactly one pulse. Eret with EPC=0x8000_0400 -> Redirect_PC=0x8000_0400, EXL=0.
- TLBRefillinIF with EXL=1 -> Redirect_PC=0xBFC0_0380; EPC unchanged.
